addsub_arbiter: RTL

Arbiter and sequencer that shares one 4-bit ripple-carry adder/subtractor (`four_bit_RCA_RCS`) between two independent requesters.
- Each requester presents an opcode and two operands on a valid/ready channel.
- The block grants one request at a time (round-robin or fixed priority) and drives the shared adder from registered operands.
- It returns the 4-bit result, carry-out and signed-overflow flag, tagged with the requester ID, on a single valid/ready response channel.
- It sits between the two operand sources and the arithmetic datapath, and is the only driver of the adder's A, B and Cin.

---
 rtl/addsub_arbiter_if.sv | 25 ++
 rtl/addsub_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/addsub_arbiter_if.sv
// Two-requester operand channels plus one tagged response channel for addsub_arbiter.
// master = requesters/consumer side, slave = arbiter side.
interface addsub_arbiter_if;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [1:0] req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [3:0] rsp_s;
  logic       rsp_cout;
  logic       rsp_ovf;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_s, rsp_cout, rsp_ovf
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_s, rsp_cout, rsp_ovf
  );
endinterface

// File: rtl/addsub_arbiter.sv
// Shares one 4-bit ripple adder/subtractor between two requesters; accept edge T, rsp_valid after T+1.
// One op in flight; req_ready low until the response handshakes, response held while rsp_ready is low.
module addsub_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input logic             clk,
  input logic             rst,
  addsub_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state_q, state_d;
  logic       prio_q, prio_d;
  logic [3:0] op_a_q, op_a_d;
  logic [3:0] op_b_q, op_b_d;
  logic       op_sub_q, op_sub_d;
  logic       id_q, id_d;
  logic [3:0] rsp_s_q, rsp_s_d;
  logic       rsp_cout_q, rsp_cout_d;
  logic       rsp_ovf_q, rsp_ovf_d;

  logic       grant;
  logic [1:0] req_ready_c;
  logic [3:0] sum;
  logic       carry;
  logic [3:0] b_eff;
  logic       ovf;

  four_bit_RCA_RCS u_rca (
    .a    (op_a_q),
    .b    (op_b_q),
    .cin  (op_sub_q),
    .s    (sum),
    .cout (carry)
  );

  // Overflow is judged against the operand the adder actually sees (inverted B on subtract).
  assign b_eff = op_sub_q ? ~op_b_q : op_b_q;
  assign ovf   = (op_a_q[3] == b_eff[3]) && (sum[3] != op_a_q[3]);

  always_comb begin
    grant = 1'b0;
    unique case (bus.req_valid)
      2'b10:   grant = 1'b1;
      2'b11:   grant = RR_EN ? prio_q : 1'b0;
      default: grant = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_sub_d    = op_sub_q;
    id_d        = id_q;
    rsp_s_d     = rsp_s_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_ovf_d   = rsp_ovf_q;
    req_ready_c = 2'b00;

    unique case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          req_ready_c[grant] = 1'b1;
          op_a_d   = grant ? bus.req_a[7:4] : bus.req_a[3:0];
          op_b_d   = grant ? bus.req_b[7:4] : bus.req_b[3:0];
          op_sub_d = bus.req_op[grant];
          id_d     = grant;
          // Pointer moves even for a lone requester so it never sticks on one side.
          prio_d   = RR_EN ? ~grant : prio_q;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_s_d    = sum;
        rsp_cout_d = carry;
        rsp_ovf_d  = ovf;
        state_d    = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      op_a_q     <= 4'h0;
      op_b_q     <= 4'h0;
      op_sub_q   <= 1'b0;
      id_q       <= 1'b0;
      rsp_s_q    <= 4'h0;
      rsp_cout_q <= 1'b0;
      rsp_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_sub_q   <= op_sub_d;
      id_q       <= id_d;
      rsp_s_q    <= rsp_s_d;
      rsp_cout_q <= rsp_cout_d;
      rsp_ovf_q  <= rsp_ovf_d;
    end
  end

  assign bus.req_ready = rst ? 2'b00 : req_ready_c;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_s     = rsp_s_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_ovf   = rsp_ovf_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(bus.req_ready));

  a_rsp_hold: assert property (@(posedge clk) disable iff (rst)
    (bus.rsp_valid && !bus.rsp_ready) |=>
      (bus.rsp_valid && $stable({bus.rsp_id, bus.rsp_s, bus.rsp_cout, bus.rsp_ovf})));

endmodule

module four_bit_RCA_RCS (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  // Cin doubles as the subtract select: A + ~B + 1.
  logic [4:0] c;
  logic [3:0] bx;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign bx[i]   = b[i] ^ cin;
    assign s[i]    = a[i] ^ bx[i] ^ c[i];
    assign c[i+1]  = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
  end

  assign cout = c[4];
endmodule
